// File: rtl/iv_bus_responder.sv
// IV-bus peripheral: decodes select/write commands on one IV bank, exposes a
// DATA register (receive FIFO on write, transmit holding byte on read) and a
// STATUS register, and bridges both to a user-side valid/ready interface.
module iv_bus_responder #(
  parameter logic [7:0]  DEV_ADDR = 8'h10,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] n_IV_in,
  input  logic       IO_SC,
  input  logic       IO_WC,
  input  logic       bank_n_w,
  input  logic       bank_n_r,
  output logic [7:0] n_IV_out,
  output logic       IV_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [7:0] StatusAddr = DEV_ADDR + 8'd1;

  logic [7:0] iv;
  logic       select_ev, write_ev;
  logic       sel_q, sel_d, reg_sel_q, reg_sel_d;
  logic       oe_q, rd_sel_q, rd_sel_d, strobe_end;
  logic       push_req, push_ok, pop, flush, fifo_full, ovf_set;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [7:0] mem_q [DEPTH];
  logic       tx_full_q, tx_full_d, tx_load, tx_clear;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] status, rd_byte;

  assign iv = ~n_IV_in;

  // Command decode; SC wins when both strobes are high.
  assign select_ev = IO_SC & ~bank_n_w;
  assign write_ev  = IO_WC & ~IO_SC & ~bank_n_w & sel_q;

  // Read drive is purely combinational from registered selection.
  assign IV_oe      = sel_q & ~bank_n_r & ~IO_SC & ~IO_WC;
  assign strobe_end = oe_q & ~IV_oe;

  assign fifo_full = (count_q == FullCnt);
  assign rx_valid  = (count_q != '0);
  assign rx_data   = mem_q[rd_ptr_q];
  assign tx_ready  = ~tx_full_q;

  assign pop      = rx_valid & rx_ready;
  assign push_req = write_ev & ~reg_sel_q;
  assign push_ok  = push_req & (~fifo_full | pop);
  assign ovf_set  = push_req & fifo_full & ~pop;
  assign flush    = write_ev & reg_sel_q & iv[0];

  assign tx_load  = tx_valid & tx_ready;
  assign tx_clear = (strobe_end & ~rd_sel_q) | (write_ev & reg_sel_q & iv[1]);

  // Selection next state, plus which register the current read targets.
  always_comb begin
    sel_d     = sel_q;
    reg_sel_d = reg_sel_q;
    rd_sel_d  = rd_sel_q;
    if (select_ev) begin
      sel_d     = (iv == DEV_ADDR) | (iv == StatusAddr);
      reg_sel_d = (iv == StatusAddr);
    end
    if (IV_oe) rd_sel_d = reg_sel_q;
  end

  // FIFO pointers, count and overflow flag; flush overrides a same-cycle pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
    // Set wins over the read-side clear in the same cycle.
    if (strobe_end & rd_sel_q) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  // Transmit holding register; a user load beats any same-cycle clear.
  always_comb begin
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    if (tx_load) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data;
    end else if (tx_clear) begin
      tx_full_d = 1'b0;
    end
  end

  // Read mux and active-low bus drive.
  always_comb begin
    status   = {5'(count_q), ovf_q, fifo_full, tx_full_q};
    rd_byte  = reg_sel_q ? status : (tx_full_q ? tx_byte_q : 8'h00);
    n_IV_out = IV_oe ? ~rd_byte : 8'hFF;
  end

  // Control and status state.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sel_q     <= 1'b0;
      reg_sel_q <= 1'b0;
      oe_q      <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_full_q <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      sel_q     <= sel_d;
      reg_sel_q <= reg_sel_d;
      oe_q      <= IV_oe;
      rd_sel_q  <= rd_sel_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_full_q <= tx_full_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // FIFO storage; cleared on reset so rx_data reads 00 afterwards.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= iv;
    end
  end

endmodule
